emu_vector_sequencer: RTL

- Host-side controller for the co-emulation wrapper.
- Receives stimulus bytes over a valid/ready byte stream and writes them into the wrapper's stimulus array through Din_emu/Addr_emu.
- Fires load_emu, waits a programmable settle time, then fires get_emu.
- Reads the output vector back byte by byte through Dout_emu and streams it to the host.
- Runs entirely in the clk_emu domain.

---
 rtl/emu_vector_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/emu_vector_sequencer.sv
// Host-side co-emulation sequencer: streams stimulus bytes into the wrapper, strobes load/get, streams results back.
// Latency: 2*NUM_STIM + 1 + WAIT_CYC + 1 + 3*NUM_OUT cycles per vector with no stalls.
// Backpressure: rx_ready drops outside S_RX; tx_valid holds data indefinitely until tx_ready.
module emu_vector_sequencer #(
    parameter int NUM_STIM = 1,
    parameter int NUM_OUT  = 3,
    parameter int ADDR_W   = 3,
    parameter int WAIT_CYC = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk_emu,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        Din_emu,
    output logic [ADDR_W-1:0] Addr_emu,
    output logic              load_emu,
    output logic              get_emu,
    input  logic [7:0]        Dout_emu,
    output logic              busy,
    output logic [CNT_W-1:0]  vec_count
);

    typedef enum logic [2:0] {
        S_RX, S_WR, S_LOAD, S_WAIT, S_GET, S_RDA, S_RDS, S_TX
    } state_t;

    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_STIM = IDX_W'(NUM_STIM - 1);
    localparam logic [IDX_W-1:0] LAST_OUT  = IDX_W'(NUM_OUT - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sidx_q, sidx_d;
    logic [IDX_W-1:0]   oidx_q, oidx_d;
    logic [7:0]         wcnt_q, wcnt_d;
    logic [7:0]         din_q, din_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               load_q, load_d;
    logic               get_q, get_d;
    logic [7:0]         txd_q, txd_d;
    logic               txv_q, txv_d;
    logic [CNT_W-1:0]   vcnt_q, vcnt_d;

    // Strobes are registered, so they are raised on the transition into their state.
    always_comb begin
        state_d = state_q;
        sidx_d  = sidx_q;
        oidx_d  = oidx_q;
        wcnt_d  = wcnt_q;
        din_d   = din_q;
        addr_d  = addr_q;
        load_d  = 1'b0;
        get_d   = 1'b0;
        txd_d   = txd_q;
        txv_d   = txv_q;
        vcnt_d  = vcnt_q;
        case (state_q)
            S_RX: begin
                if (rx_valid) begin
                    din_d   = rx_data;
                    addr_d  = ADDR_W'(sidx_q);
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (sidx_q == LAST_STIM) begin
                    sidx_d  = '0;
                    load_d  = 1'b1;
                    state_d = S_LOAD;
                end else begin
                    sidx_d  = sidx_q + IDX_W'(1);
                    state_d = S_RX;
                end
            end
            S_LOAD: begin
                wcnt_d = 8'(WAIT_CYC);
                if (WAIT_CYC == 0) begin
                    get_d   = 1'b1;
                    state_d = S_GET;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q - 8'd1;
                if (wcnt_q <= 8'd1) begin
                    get_d   = 1'b1;
                    state_d = S_GET;
                end
            end
            S_GET: begin
                addr_d  = '0;
                oidx_d  = '0;
                state_d = S_RDA;
            end
            S_RDA: state_d = S_RDS;
            S_RDS: begin
                txd_d   = Dout_emu;
                txv_d   = 1'b1;
                state_d = S_TX;
            end
            S_TX: begin
                if (tx_ready) begin
                    txv_d = 1'b0;
                    if (oidx_q == LAST_OUT) begin
                        vcnt_d  = vcnt_q + CNT_W'(1);
                        state_d = S_RX;
                    end else begin
                        oidx_d  = oidx_q + IDX_W'(1);
                        addr_d  = ADDR_W'(oidx_q + IDX_W'(1));
                        state_d = S_RDA;
                    end
                end
            end
            default: state_d = S_RX;
        endcase
    end

    always_ff @(posedge clk_emu or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RX;
            sidx_q  <= '0;
            oidx_q  <= '0;
            wcnt_q  <= '0;
            din_q   <= '0;
            addr_q  <= '0;
            load_q  <= 1'b0;
            get_q   <= 1'b0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sidx_q  <= sidx_d;
            oidx_q  <= oidx_d;
            wcnt_q  <= wcnt_d;
            din_q   <= din_d;
            addr_q  <= addr_d;
            load_q  <= load_d;
            get_q   <= get_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
            vcnt_q  <= vcnt_d;
        end
    end

    assign rx_ready  = (state_q == S_RX);
    assign busy      = !((state_q == S_RX) && (sidx_q == '0));
    assign tx_data   = txd_q;
    assign tx_valid  = txv_q;
    assign Din_emu   = din_q;
    assign Addr_emu  = addr_q;
    assign load_emu  = load_q;
    assign get_emu   = get_q;
    assign vec_count = vcnt_q;

endmodule
